// File: rtl/lcd_cmd_scheduler_if.sv
// Command-port bundle between the two requesters, the LCD controller and the scheduler.
// The requester/controller side uses the master modport; the scheduler uses the slave modport.
interface lcd_cmd_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       a_cmd;
  logic             a_valid;
  logic             a_ready;
  logic [3:0]       b_cmd;
  logic             b_valid;
  logic             b_ready;
  logic [3:0]       lcd_cmd;
  logic             lcd_cmd_valid;
  logic             lcd_busy;
  logic             lcd_done;
  logic             grant_id;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             seq_done;

  modport master (
    output a_cmd, a_valid, b_cmd, b_valid, lcd_busy, lcd_done,
    input  a_ready, b_ready, lcd_cmd, lcd_cmd_valid, grant_id, issued_cnt, err_cnt, seq_done
  );

  modport slave (
    input  a_cmd, a_valid, b_cmd, b_valid, lcd_busy, lcd_done,
    output a_ready, b_ready, lcd_cmd, lcd_cmd_valid, grant_id, issued_cnt, err_cnt, seq_done
  );
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// Round-robin scheduler sharing the LCD controller command port between two FIFO-fed
// requesters; the sequence ends after the first WRITE (code 0) and the controller's done.
module lcd_cmd_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              reset,
  lcd_cmd_scheduler_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_GUARD  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [3:0]        lcd_cmd_q, lcd_cmd_d;
  logic              lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic              grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              seq_done_q, seq_done_d;
  logic              closed_q, closed_d;

  logic [3:0]        mem_a_q [DEPTH];
  logic [3:0]        mem_b_q [DEPTH];
  logic [PTR_W-1:0]  wp_a_q, wp_a_d, rp_a_q, rp_a_d;
  logic [PTR_W-1:0]  wp_b_q, wp_b_d, rp_b_q, rp_b_d;
  logic [CNT_FW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic              a_ready_c, b_ready_c;
  logic              push_a, push_b, store_a, store_b, bad_a, bad_b;
  logic              ne_a, ne_b, pop_a, pop_b, sel_b, flush;
  logic [1:0]        err_inc;
  logic [CNT_W:0]    err_sum;

  // Push-side handshake: illegal codes complete the handshake but are never stored.
  always_comb begin
    a_ready_c = (cnt_a_q != CNT_FW'(DEPTH)) && !closed_q;
    b_ready_c = (cnt_b_q != CNT_FW'(DEPTH)) && !closed_q;
    push_a    = bus.a_valid && a_ready_c;
    push_b    = bus.b_valid && b_ready_c;
    bad_a     = bus.a_cmd >= 4'd12;
    bad_b     = bus.b_cmd >= 4'd12;
    store_a   = push_a && !bad_a;
    store_b   = push_b && !bad_b;
    ne_a      = cnt_a_q != '0;
    ne_b      = cnt_b_q != '0;
    err_inc   = {1'b0, push_a && bad_a} + {1'b0, push_b && bad_b};
    err_sum   = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_inc);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    lcd_cmd_d       = lcd_cmd_q;
    lcd_cmd_valid_d = 1'b0;
    grant_id_d      = grant_id_q;
    issued_cnt_d    = issued_cnt_q;
    seq_done_d      = seq_done_q;
    closed_d        = closed_q || (push_a && bus.a_cmd == 4'd0) || (push_b && bus.b_cmd == 4'd0);
    err_cnt_d       = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    sel_b           = 1'b0;
    pop_a           = 1'b0;
    pop_b           = 1'b0;
    flush           = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (!bus.lcd_busy) state_d = ST_READY;
      end
      ST_READY: begin
        if (!bus.lcd_busy && (ne_a || ne_b)) begin
          sel_b           = (ne_a && ne_b) ? !grant_id_q : ne_b;
          pop_a           = !sel_b;
          pop_b           = sel_b;
          lcd_cmd_d       = sel_b ? mem_b_q[rp_b_q] : mem_a_q[rp_a_q];
          lcd_cmd_valid_d = 1'b1;
          grant_id_d      = sel_b;
          issued_cnt_d    = (issued_cnt_q == '1) ? issued_cnt_q : issued_cnt_q + CNT_W'(1);
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_GUARD;
      // Busy only rises one cycle after accept, so it is not trusted here.
      ST_GUARD: state_d = (lcd_cmd_q == 4'd0) ? ST_FINISH : ST_WAIT;
      ST_WAIT: begin
        if (!bus.lcd_busy) state_d = ST_READY;
      end
      ST_FINISH: begin
        flush = 1'b1;
        if (bus.lcd_done) begin
          seq_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase

    wp_a_d  = store_a ? wp_a_q + PTR_W'(1) : wp_a_q;
    rp_a_d  = pop_a ? rp_a_q + PTR_W'(1) : rp_a_q;
    cnt_a_d = cnt_a_q + CNT_FW'(store_a) - CNT_FW'(pop_a);
    wp_b_d  = store_b ? wp_b_q + PTR_W'(1) : wp_b_q;
    rp_b_d  = pop_b ? rp_b_q + PTR_W'(1) : rp_b_q;
    cnt_b_d = cnt_b_q + CNT_FW'(store_b) - CNT_FW'(pop_b);
    if (flush) begin
      wp_a_d  = '0;
      rp_a_d  = '0;
      cnt_a_d = '0;
      wp_b_d  = '0;
      rp_b_d  = '0;
      cnt_b_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_LOAD;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      grant_id_q      <= 1'b1;
      issued_cnt_q    <= '0;
      err_cnt_q       <= '0;
      seq_done_q      <= 1'b0;
      closed_q        <= 1'b0;
      wp_a_q          <= '0;
      rp_a_q          <= '0;
      cnt_a_q         <= '0;
      wp_b_q          <= '0;
      rp_b_q          <= '0;
      cnt_b_q         <= '0;
    end else begin
      state_q         <= state_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      grant_id_q      <= grant_id_d;
      issued_cnt_q    <= issued_cnt_d;
      err_cnt_q       <= err_cnt_d;
      seq_done_q      <= seq_done_d;
      closed_q        <= closed_d;
      wp_a_q          <= wp_a_d;
      rp_a_q          <= rp_a_d;
      cnt_a_q         <= cnt_a_d;
      wp_b_q          <= wp_b_d;
      rp_b_q          <= rp_b_d;
      cnt_b_q         <= cnt_b_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (store_a) mem_a_q[wp_a_q] <= bus.a_cmd;
    if (store_b) mem_b_q[wp_b_q] <= bus.b_cmd;
  end

  assign bus.a_ready       = a_ready_c;
  assign bus.b_ready       = b_ready_c;
  assign bus.lcd_cmd       = lcd_cmd_q;
  assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.issued_cnt    = issued_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.seq_done      = seq_done_q;
endmodule
